// File: rtl/game_event_sched_pkg.sv
// Shared types and defaults for the game event scheduler and its arbiters.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } game_state_e;

  localparam int HP_MAX_DEF      = 5;
  localparam int BONUS_STEP_DEF  = 10;
  localparam int BONUS_LIMIT_DEF = 30;
  localparam int HP_W            = 3;
  localparam int LED_W           = 5;

  // Thermometer fill from the MSB: the first life lights the leftmost LED.
  function automatic logic [LED_W-1:0] hp_to_led(input logic [HP_W-1:0] hp);
    logic [LED_W-1:0] led;
    led = '0;
    for (int i = 0; i < LED_W; i++) begin
      if (i < int'(hp)) led[LED_W-1-i] = 1'b1;
    end
    return led;
  endfunction

endpackage

// File: rtl/game_event_sched_if.sv
// Request/ack and status bundle between the event sources and the scheduler.
interface game_event_sched_if
  import game_pkg::*;
#(
  parameter int NUM_ENY = 4,
  parameter int SCORE_W = 7
);
  logic               game_en;
  logic               hit_req;
  logic               hit_ack;
  logic [NUM_ENY-1:0] kill_req;
  logic [NUM_ENY-1:0] kill_ack;
  logic [HP_W-1:0]    hp_value;
  logic [SCORE_W-1:0] score;
  logic [LED_W-1:0]   hp_led;
  logic               game_over;
  logic [1:0]         state;

  modport master (
    output game_en, hit_req, kill_req,
    input  hit_ack, kill_ack, hp_value, score, hp_led, game_over, state
  );

  modport slave (
    input  game_en, hit_req, kill_req,
    output hit_ack, kill_ack, hp_value, score, hp_led, game_over, state
  );
endinterface

// File: rtl/game_event_sched_rr_arbiter.sv
// Round-robin arbiter with request mask; the pointer only advances when the
// caller actually consumes the grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] mask_i,
  input  logic         advance_i,
  output logic [N-1:0] grant_o,
  output logic         valid_o
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;
  logic [N-1:0]  eligible;
  logic          found;

  assign eligible = req_i & ~mask_i;
  assign valid_o  = |eligible;

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_q) + k) % N);
      if (!found && eligible[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        ptr_d        = PW'((int'(idx) + 1) % N);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   ptr_q <= '0;
    else if (advance_i && found)  ptr_q <= ptr_d;
  end

endmodule

// File: rtl/game_event_sched.sv
// Game event scheduler: serialises hit and kill requests through one update
// path and owns HP, score, bonus milestones and the IDLE/PLAY/OVER state.
module game_event_sched
  import game_pkg::*;
#(
  parameter int HP_MAX      = HP_MAX_DEF,
  parameter int NUM_ENY     = 4,
  parameter int SCORE_W     = 7,
  parameter int BONUS_STEP  = BONUS_STEP_DEF,
  parameter int BONUS_LIMIT = BONUS_LIMIT_DEF
) (
  input logic               clk,
  input logic               rst_n,
  game_event_sched_if.slave bus
);

  game_state_e        state_q, state_d;
  logic [HP_W-1:0]    hp_q, hp_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] bonus_q, bonus_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               over_q;
  logic               hit_ack_q, hit_ack_d;
  logic [NUM_ENY-1:0] kill_ack_q, kill_ack_d;
  logic [NUM_ENY-1:0] kill_grant;
  logic               kill_valid;
  logic               grant_en, hit_take, kill_take;

  // Starting a game or leaving PLAY takes the whole edge; pending requests
  // wait one cycle. An ack still high masks its own requester.
  assign grant_en  = !((state_q == ST_IDLE && bus.game_en) ||
                       (state_q == ST_PLAY && !bus.game_en));
  assign hit_take  = grant_en && bus.hit_req && !hit_ack_q;
  assign kill_take = grant_en && !hit_take && kill_valid;

  rr_arbiter #(.N(NUM_ENY)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (bus.kill_req),
    .mask_i    (kill_ack_q),
    .advance_i (kill_take),
    .grant_o   (kill_grant),
    .valid_o   (kill_valid)
  );

  always_comb begin
    state_d    = state_q;
    hp_d       = hp_q;
    score_d    = score_q;
    bonus_d    = bonus_q;
    hit_ack_d  = hit_take;
    kill_ack_d = kill_take ? kill_grant : '0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.game_en) begin
          state_d = ST_PLAY;
          hp_d    = HP_W'(HP_MAX);
          score_d = '0;
          bonus_d = SCORE_W'(BONUS_STEP);
        end
      end
      ST_PLAY: begin
        if (!bus.game_en) begin
          state_d = ST_IDLE;
        end else if (hit_take) begin
          if (hp_q != '0)             hp_d    = hp_q - 1'b1;
          if (hp_q <= HP_W'(1))       state_d = ST_OVER;
        end else if (kill_take) begin
          score_d = (&score_q) ? score_q : score_q + 1'b1;
          // A milestone is spent even when HP is already full.
          if (score_d == bonus_q && bonus_q <= SCORE_W'(BONUS_LIMIT)) begin
            hp_d    = (hp_q >= HP_W'(HP_MAX)) ? hp_q : hp_q + 1'b1;
            bonus_d = bonus_q + SCORE_W'(BONUS_STEP);
          end
        end
      end
      ST_OVER: begin
        if (!bus.game_en) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    led_d = hp_to_led(hp_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hp_q       <= HP_W'(HP_MAX);
      score_q    <= '0;
      bonus_q    <= SCORE_W'(BONUS_STEP);
      led_q      <= hp_to_led(HP_W'(HP_MAX));
      over_q     <= 1'b0;
      hit_ack_q  <= 1'b0;
      kill_ack_q <= '0;
    end else begin
      state_q    <= state_d;
      hp_q       <= hp_d;
      score_q    <= score_d;
      bonus_q    <= bonus_d;
      led_q      <= led_d;
      over_q     <= (state_d == ST_OVER);
      hit_ack_q  <= hit_ack_d;
      kill_ack_q <= kill_ack_d;
    end
  end

  assign bus.hit_ack   = hit_ack_q;
  assign bus.kill_ack  = kill_ack_q;
  assign bus.hp_value  = hp_q;
  assign bus.score     = score_q;
  assign bus.hp_led    = led_q;
  assign bus.game_over = over_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_game_event_sched.sv
// Scoreboard bench for game_event_sched: a driver steps requesters and a
// reference model at negedge, a monitor compares every registered output.
module tb_game_event_sched;
  import game_pkg::*;

  localparam int NE   = 4;
  localparam int SW   = 7;
  localparam int SMAX = (1 << SW) - 1;

  typedef struct {
    int state;
    int hp;
    int score;
    int hit;
    int kill;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_on = 1'b0;

  int m_state, m_hp, m_score, m_nb, m_ptr, m_hit, m_kill;

  bit          en, h_req, h_late, rnd_on, en_toggle;
  logic [NE-1:0] k_req, k_late;
  int          p_hit, p_kill;

  int ep_hit [4] = '{20, 0, 100, 30};
  int ep_kill[4] = '{250, 400, 200, 300};
  int ep_len [4] = '{400, 600, 300, 400};

  always #5 clk = ~clk;

  game_event_sched_if #(.NUM_ENY(NE), .SCORE_W(SW)) bus ();

  game_event_sched #(
    .HP_MAX(5), .NUM_ENY(NE), .SCORE_W(SW), .BONUS_STEP(10), .BONUS_LIMIT(30)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string name, input bit ok, input string got, input string want);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %s, want %s", name, got, want);
    end
  endtask

  function automatic int exp_led(input int hp);
    return ((1 << hp) - 1) << (5 - hp);
  endfunction

  function automatic int onehot_idx(input logic [NE-1:0] v);
    if (v == '0) return -1;
    if ($countones(v) != 1) return -2;
    for (int i = 0; i < NE; i++) if (v[i]) return i;
    return -2;
  endfunction

  function automatic bit pending();
    return h_req || h_late || (|k_req) || (|k_late);
  endfunction

  task automatic model_reset();
    m_state = 0; m_hp = 5; m_score = 0; m_nb = 10; m_ptr = 0; m_hit = 0; m_kill = -1;
  endtask

  task automatic drive();
    bus.game_en  = en;
    bus.hit_req  = h_req;
    bus.kill_req = k_req;
  endtask

  // Reference model: what the scheduler must do at the coming posedge.
  task automatic predict();
    bit entering, leaving;
    int gh, gk;
    gh = 0; gk = -1;
    entering = (m_state == 0) && en;
    leaving  = (m_state == 1) && !en;
    if (!entering && !leaving) begin
      if (h_req && m_hit == 0) gh = 1;
      else begin
        for (int k = 0; k < NE; k++) begin
          int i;
          i = (m_ptr + k) % NE;
          if (gk < 0 && k_req[i] && m_kill != i) gk = i;
        end
      end
    end
    if (gk >= 0) m_ptr = (gk + 1) % NE;
    case (m_state)
      0: if (en) begin m_state = 1; m_hp = 5; m_score = 0; m_nb = 10; end
      1: begin
        if (!en) m_state = 0;
        else if (gh == 1) begin
          m_hp = m_hp - 1;
          if (m_hp == 0) m_state = 2;
        end else if (gk >= 0) begin
          m_score = (m_score < SMAX) ? m_score + 1 : SMAX;
          if (m_score == m_nb && m_nb <= 30) begin
            if (m_hp < 5) m_hp = m_hp + 1;
            m_nb = m_nb + 10;
          end
        end
      end
      default: if (!en) m_state = 0;
    endcase
    m_hit  = gh;
    m_kill = gk;
    exp_q.push_back('{m_state, m_hp, m_score, gh, gk});
    mon_on = 1'b1;
  endtask

  task automatic check_reset(input string name);
    check({name, "_acks"}, bus.hit_ack === 1'b0 && bus.kill_ack === '0,
          $sformatf("hit=%b kill=%b", bus.hit_ack, bus.kill_ack), "0/0000");
    check({name, "_state"}, bus.state === 2'd0 && bus.game_over === 1'b0,
          $sformatf("st=%0d go=%b", bus.state, bus.game_over), "st=0 go=0");
    check({name, "_vals"}, bus.hp_value === 3'd5 && bus.hp_led === 5'b11111 && bus.score === '0,
          $sformatf("hp=%0d led=%b sc=%0d", bus.hp_value, bus.hp_led, bus.score),
          "hp=5 led=11111 sc=0");
  endtask

  task automatic step(input bit do_rst);
    @(negedge clk);
    if (do_rst) begin
      check("ack_before_reset", bus.kill_ack[1] === 1'b1,
            $sformatf("%b", bus.kill_ack), "0010");
      rst_n = 1'b0;
      #1;
      check_reset("mid_reset");
      rst_n = 1'b1;
      #1;
      model_reset();
    end
    if (h_late) begin h_req = 1'b0; h_late = 1'b0; end
    else if (h_req && bus.hit_ack) begin
      if ($urandom_range(0, 3) == 0) h_late = 1'b1; else h_req = 1'b0;
    end
    for (int k = 0; k < NE; k++) begin
      if (k_late[k]) begin k_req[k] = 1'b0; k_late[k] = 1'b0; end
      else if (k_req[k] && bus.kill_ack[k]) begin
        if ($urandom_range(0, 3) == 0) k_late[k] = 1'b1; else k_req[k] = 1'b0;
      end
    end
    if (rnd_on) begin
      if (en_toggle && $urandom_range(0, 49) == 0) en = !en;
      if (!h_req && !bus.hit_ack && $urandom_range(0, 999) < p_hit) h_req = 1'b1;
      for (int k = 0; k < NE; k++)
        if (!k_req[k] && !bus.kill_ack[k] && $urandom_range(0, 999) < p_kill) k_req[k] = 1'b1;
    end
    drive();
    predict();
  endtask

  task automatic drain(input int max_cycles);
    rnd_on = 1'b0;
    for (int c = 0; c < max_cycles && pending(); c++) step(1'b0);
    check("drain", !pending(), $sformatf("pending h=%b k=%b", h_req, k_req), "all acked");
  endtask

  task automatic kill_one(input int idx);
    k_req[idx] = 1'b1;
    drain(10);
  endtask

  initial begin : monitor
    exp_t  e;
    int    gk;
    bit    ok;
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) begin
        if (exp_q.size() == 0) begin
          check("expect_queue", 1'b0, "empty", "one entry per cycle");
        end else begin
          e  = exp_q.pop_front();
          gk = onehot_idx(bus.kill_ack);
          ok = (int'(bus.state) == e.state) && (int'(bus.hp_value) == e.hp) &&
               (int'(bus.score) == e.score) && (int'(bus.hp_led) == exp_led(e.hp)) &&
               (bus.game_over == (e.state == 2)) && (int'(bus.hit_ack) == e.hit) &&
               (gk == e.kill);
          check("cycle", ok,
                $sformatf("st=%0d hp=%0d sc=%0d led=%b go=%b hack=%b kack=%0d",
                          bus.state, bus.hp_value, bus.score, bus.hp_led, bus.game_over,
                          bus.hit_ack, gk),
                $sformatf("st=%0d hp=%0d sc=%0d led=%b go=%b hack=%0d kack=%0d",
                          e.state, e.hp, e.score, 5'(exp_led(e.hp)), (e.state == 2),
                          e.hit, e.kill));
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL timeout: got no finish, want finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    en = 1'b0; h_req = 1'b0; h_late = 1'b0; k_req = '0; k_late = '0;
    rnd_on = 1'b0; en_toggle = 1'b0; p_hit = 0; p_kill = 0;
    model_reset();
    drive();
    #12;
    check_reset("reset");
    rst_n = 1'b1;

    en = 1'b1;
    step(1'b0);
    k_req = '1;
    drain(20);

    for (int n = 0; n < 2; n++) begin h_req = 1'b1; drain(10); end
    for (int n = 0; n < 36; n++) kill_one(n % NE);

    for (int n = 0; n < 8 && m_hp > 1; n++) begin h_req = 1'b1; drain(10); end
    h_req = 1'b1;
    k_req[2] = 1'b1;
    drain(10);

    en = 1'b0; step(1'b0); step(1'b0);
    en = 1'b1; step(1'b0); step(1'b0);

    k_req[1] = 1'b1;
    step(1'b0);
    step(1'b1);
    drain(10);

    for (int e = 0; e < 4; e++) begin
      en = 1'b1;
      p_hit = ep_hit[e];
      p_kill = ep_kill[e];
      en_toggle = (e == 3);
      rnd_on = 1'b1;
      for (int c = 0; c < ep_len[e]; c++) step(1'b0);
    end

    en = 1'b0;
    drain(60);
    step(1'b0);
    step(1'b0);
    @(posedge clk);
    #3;
    check("queue_empty", exp_q.size() == 0, $sformatf("%0d left", exp_q.size()), "0 left");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_event_sched.md
Name: game_event_sched

Overview:
- Central scheduler for game scoring and player health.
- Serialises player-hit events and enemy-kill events from four enemy tanks through one update path, using a per-requester req/ack handshake.
- Owns the HP counter, total score, bonus-life milestones and the game IDLE/PLAY/OVER state.
- Feeds the HP LED bar and the score digits of the seven-segment display.

Parameters:
- HP_MAX, 5, starting and maximum HP (fits 3 bits).
- NUM_ENY, 4, number of enemy kill requesters.
- SCORE_W, 7, score register width.
- BONUS_STEP, 10, score interval that grants +1 HP.
- BONUS_LIMIT, 30, last score at which a bonus is granted.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- game_en  in  1  level; high = game running.
- hit_req  in  1  player tank hit; held until hit_ack.
- hit_ack  out  1  one-cycle acknowledge of hit_req.
- kill_req  in  NUM_ENY  per-enemy kill request; held until acked.
- kill_ack  out  NUM_ENY  one-hot, one-cycle acknowledge.
- hp_value  out  3  current HP.
- score  out  SCORE_W  current total score.
- hp_led  out  5  thermometer of HP; bit 4 = first life.
- game_over  out  1  high while in OVER.
- state  out  2  IDLE=0, PLAY=1, OVER=2.

Behaviour:
- Reset (async, rst_n low) sets:
  - state=IDLE, hp_value=HP_MAX, score=0, next_bonus=BONUS_STEP;
  - hit_ack=0, kill_ack=0, rr pointer=0;
  - hp_led=5'b11111, game_over=0.
- All outputs are registered.
- FSM transitions:
  - IDLE -> PLAY on the first edge where game_en=1. On that edge load hp_value=HP_MAX, score=0, next_bonus=BONUS_STEP. No grants are issued on the entry edge.
  - PLAY -> IDLE when game_en=0, with priority over any pending event. hp_value and score hold their last values.
  - PLAY -> OVER on the edge where a granted hit brings hp_value to 0.
  - OVER -> IDLE when game_en=0. Values hold.
- Arbitration in PLAY: at most one grant per cycle.
  - hit_req has fixed highest priority.
  - Otherwise the four kill_req inputs are served round-robin, starting from the pointer. After a kill grant, the pointer moves to granted index+1 mod NUM_ENY.
- Handshake and latency:
  - A request sampled high at edge N is granted at edge N: ack is high during cycle N+1 and the effect on hp/score/led is visible in cycle N+1.
  - The requester drops req in the cycle its ack is high. The arbiter masks any requester whose ack is currently high, so a held request never counts twice.
- Hit grant:
  - hp_value -= 1.
  - hp_value never wraps below 0; hits are unreachable at 0 because the FSM is in OVER by then.
- Kill grant:
  - score += 1, saturating at 2^SCORE_W-1.
  - If the new score == next_bonus and next_bonus <= BONUS_LIMIT: hp_value = min(hp_value+1, HP_MAX) and next_bonus += BONUS_STEP.
  - The bonus is consumed even when HP is already at HP_MAX.
- Simultaneous hit and kill: the hit is served first and the kill next cycle. A hit that empties HP sends the FSM to OVER, and the pending kill is drained without scoring.
- Drain in IDLE and OVER: requests are still acked one per cycle, same priority and rr rules, with no effect on hp/score. Requesters never hang.
- hp_led is a registered thermometer code of hp_value: 0->00000, 1->10000, ..., 5->11111.
- game_over = (state==OVER).
- rst_n asserted mid-handshake clears acks immediately. Requests that survive reset are served afresh after release.

Decomposition:
- Package game_pkg holds:
  - state encoding constants (ST_IDLE, ST_PLAY, ST_OVER);
  - HP_MAX, BONUS_STEP, BONUS_LIMIT defaults;
  - the hp-to-thermometer LED function.
- Sub-module rr_arbiter: NUM_ENY-wide round-robin arbiter with mask input, one-hot grant and pointer update. It is shared with future bullet/collision arbitration.

Test Plan:
- Reset, then game_en=1 for 1 cycle: state=PLAY, hp_value=5, hp_led=11111, score=0, no acks in the entry cycle.
- kill_req[0..3] held simultaneously: kill_ack order 0,1,2,3 on consecutive cycles; score=4; each req dropped on its ack with no double count.
- Reach score=9 with hp=3, then one kill: score=10, hp=4, hp_led=11110. Reach score=20 with hp=5: hp stays 5, next bonus moves to 30. Score 40: no bonus.
- hit_req and kill_req[2] asserted in the same cycle with hp=1: hit_ack first, hp=0, state=OVER, game_over=1, hp_led=00000. Next cycle kill_ack[2] with score unchanged.
- In OVER, drop game_en: state=IDLE, hp/score hold. Raise game_en: hp=5, score=0.
- rst_n pulsed low while kill_ack[1] high: ack clears asynchronously, state=IDLE, score=0; the held kill_req[1] is acked after reset release and game start.
